// File: rtl/sync_fifo_rd_port.sv
// Read side of a synchronous FIFO.
// It reads the memory combinationally at rd_ptr and presents one word from a
// single output register, with a valid/ready handshake toward the consumer.
// Pointers are ADDR_WIDTH+1 bits wide. The MSB is a wrap bit, so the port can
// tell a full memory apart from an empty one.

`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sync_fifo_rd_port #(
   parameter int MEM_DEPTH  = `FIFO_DEPTH,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH:0]   wr_ptr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   input  logic                  flush,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   output logic [ADDR_WIDTH:0]   rd_ptr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  empty,
   output logic [ADDR_WIDTH+1:0] level,
   output logic                  ptr_err
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(MEM_DEPTH);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH:0]   mem_cnt;
   logic                  mem_empty;
   logic                  load;

   // Occupancy of the memory alone. Modular subtraction stays correct across
   // the wrap bit.
   assign mem_cnt     = wr_ptr - rd_ptr;
   assign mem_empty   = (wr_ptr == rd_ptr);
   assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

   // A pop refills the output register. It happens when the register is free
   // or is being drained this cycle.
   assign load = !mem_empty && !flush && ((state == IDLE) || out_ready);

   // All outputs below come from registered state and from wr_ptr.
   // out_ready never reaches out_valid or out_data combinationally.
   assign out_valid = (state == HOLD);
   assign empty     = mem_empty && !out_valid;
   assign level     = {1'b0, mem_cnt} + (ADDR_WIDTH+2)'(out_valid);

   // Next state of the output stage. Flush has priority over load and drain.
   always_comb begin
      // NOTE: a default is assigned first so that every path through the block
      // drives state_nxt and no latch is inferred.
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else if (load) begin
         state_nxt = HOLD;
      end else if ((state == HOLD) && out_ready) begin
         state_nxt = IDLE;
      end
   end

   // State register, read pointer and output word. Reset is synchronous and
   // overrides flush and load.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples values from before the edge, whatever the statement order.
      if (!reset_n) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         out_data <= '0;
      end else begin
         state <= state_nxt;
         if (flush) begin
            rd_ptr <= wr_ptr;
         end else if (load) begin
            rd_ptr   <= rd_ptr + 1'b1;
            out_data <= mem_rd_data;
         end
      end
   end

   // Sticky error flag. It is set when the write side claims more words than
   // the memory can hold.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr_err <= 1'b0;
      end else if (mem_cnt > DEPTH_CNT) begin
         ptr_err <= 1'b1;
      end
   end

endmodule
